branch_predictor: RTL and testbench

- Fetch-side counterpart to the EX-stage branch resolution logic. The resolver decides the branch outcome in EX; this block predicts it in IF.
- Direct-mapped BTB/BHT with 2-bit saturating counters. Gives IF a combinational next-PC prediction each cycle.
- Trained by the resolved outcome from EX. Raises a registered MISPREDICT/REDIRECT_PC one cycle after a wrong prediction resolves; this pulse drives the pipeline flush.

---
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction
// counters, trained from EX, with a registered mispredict/redirect pulse.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  input  logic        IF_VALID,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        EX_VALID,
  input  logic [31:0] EX_PC,
  input  logic        EX_IS_BRANCH,
  input  logic        EX_IS_JUMP,
  input  logic        EX_TAKEN,
  input  logic [31:0] EX_TARGET,
  input  logic        EX_PRED_TAKEN,
  input  logic [31:0] EX_PRED_TARGET,
  output logic        MISPREDICT,
  output logic [31:0] REDIRECT_PC
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, ex_hit;
  logic [31:0]           ex_pc_plus4, actual_next, pred_next;
  logic                  ex_taken_eff, ex_alloc, ex_train, ex_stale, ex_tgt_we;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

  // IF: combinational lookup, always sees pre-edge table contents
  assign if_idx      = IF_PC[INDEX_BITS+1:2];
  assign if_tag      = IF_PC[31:INDEX_BITS+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign PRED_TAKEN  = IF_VALID && if_hit && ctr_q[if_idx][1];
  assign PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : IF_PC + 32'd4;

  assign ex_idx       = EX_PC[INDEX_BITS+1:2];
  assign ex_tag       = EX_PC[31:INDEX_BITS+2];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_pc_plus4  = EX_PC + 32'd4;
  assign ex_taken_eff = EX_IS_JUMP || (EX_IS_BRANCH && EX_TAKEN);
  assign actual_next  = ex_taken_eff ? EX_TARGET : ex_pc_plus4;
  assign pred_next    = EX_PRED_TAKEN ? EX_PRED_TARGET : ex_pc_plus4;

  // Jumps win if both decode flags are set; a taken branch miss allocates.
  assign ex_alloc  = EX_VALID && (EX_IS_JUMP || (EX_IS_BRANCH && !ex_hit && EX_TAKEN));
  assign ex_train  = EX_VALID && !EX_IS_JUMP && EX_IS_BRANCH && ex_hit;
  assign ex_stale  = EX_VALID && !EX_IS_JUMP && !EX_IS_BRANCH && EX_PRED_TAKEN;
  assign ex_tgt_we = ex_alloc || (ex_train && EX_TAKEN);

  logic        mispredict_p1;
  logic [31:0] redirect_pc_p1;

  // EX -> registered redirect stage
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      mispredict_p1  <= 1'b0;
      redirect_pc_p1 <= 32'd0;
    end else begin
      if (ex_alloc) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= EX_IS_JUMP ? 2'b11 : 2'b10;
      end else if (ex_train) begin
        ctr_q[ex_idx] <= sat_ctr(ctr_q[ex_idx], EX_TAKEN);
      end else if (ex_stale) begin
        valid_q[ex_idx] <= 1'b0;
      end
      mispredict_p1  <= EX_VALID && (actual_next != pred_next);
      redirect_pc_p1 <= actual_next;
    end
  end

  // Tag/target storage carries no reset; valid bits guard it.
  always_ff @(posedge CLK) begin
    if (!RESET && ex_alloc)  tag_q[ex_idx]    <= ex_tag;
    if (!RESET && ex_tgt_we) target_q[ex_idx] <= EX_TARGET;
  end

  assign MISPREDICT  = mispredict_p1;
  assign REDIRECT_PC = redirect_pc_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset corner cases, and
// randomized traffic against an array-based reference model.
module tb_branch_predictor;
  localparam int IB    = 4;
  localparam int N_ENT = 1 << IB;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IF_PC;
  logic        IF_VALID;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic        EX_IS_BRANCH;
  logic        EX_IS_JUMP;
  logic        EX_TAKEN;
  logic [31:0] EX_TARGET;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_PRED_TARGET;
  logic        MISPREDICT;
  logic [31:0] REDIRECT_PC;

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_PC(IF_PC), .IF_VALID(IF_VALID),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC),
    .EX_IS_BRANCH(EX_IS_BRANCH), .EX_IS_JUMP(EX_IS_JUMP),
    .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
    .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
    .MISPREDICT(MISPREDICT), .REDIRECT_PC(REDIRECT_PC)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_v   [N_ENT];
  bit [31:0]   m_tag [N_ENT];
  bit [31:0]   m_tgt [N_ENT];
  int          m_ctr [N_ENT];
  bit          m_mis;
  bit [31:0]   m_rdr;

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % N_ENT);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  task automatic m_pred(input bit [31:0] pc, input bit v, output bit t, output bit [31:0] tg);
    int i;
    i  = idx_of(pc);
    t  = v && m_v[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_edge(input bit rst, input bit exv, input bit [31:0] pc, input bit br,
                        input bit jmp, input bit tk, input bit [31:0] tgt,
                        input bit ptk, input bit [31:0] ptgt);
    int i;
    bit hit;
    bit [31:0] actual, predn;
    if (rst) begin
      for (int k = 0; k < N_ENT; k++) begin
        m_v[k] = 0;
        m_ctr[k] = 1;
      end
      m_mis = 0;
      m_rdr = 0;
      return;
    end
    i      = idx_of(pc);
    hit    = m_v[i] && (m_tag[i] == tag_of(pc));
    actual = (jmp || (br && tk)) ? tgt : pc + 32'd4;
    predn  = ptk ? ptgt : pc + 32'd4;
    m_mis  = exv && (actual != predn);
    m_rdr  = actual;
    if (!exv) return;
    if (jmp) begin
      m_v[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 3;
    end else if (br && hit) begin
      m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                    : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      if (tk) m_tgt[i] = tgt;
    end else if (br && tk) begin
      m_v[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
    end else if (!br && ptk) begin
      m_v[i] = 0;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] if_pc;  logic if_v;
    logic ex_v; logic [31:0] ex_pc; logic br; logic jmp; logic tk;
    logic [31:0] tgt; logic ptk; logic [31:0] ptgt;
    logic e_pt; logic [31:0] e_ptgt; logic e_mis; logic [31:0] e_rdr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] if_pc, input logic if_v,
                              input logic ex_v, input logic [31:0] ex_pc,
                              input logic br, input logic jmp, input logic tk,
                              input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                              input logic e_pt, input logic [31:0] e_ptgt,
                              input logic e_mis, input logic [31:0] e_rdr);
    vec_t v;
    v.if_pc = if_pc; v.if_v = if_v; v.ex_v = ex_v; v.ex_pc = ex_pc;
    v.br = br; v.jmp = jmp; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_rdr = e_rdr;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [31:0] if_pc, input logic if_v,
                       input logic ex_v, input logic [31:0] ex_pc, input logic br,
                       input logic jmp, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    RESET = rst; IF_PC = if_pc; IF_VALID = if_v;
    EX_VALID = ex_v; EX_PC = ex_pc; EX_IS_BRANCH = br; EX_IS_JUMP = jmp;
    EX_TAKEN = tk; EX_TARGET = tgt; EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptgt;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    idle();
    RESET = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("reset_mispredict", {31'd0, MISPREDICT}, 32'd0);
    check("reset_redirect", REDIRECT_PC, 32'd0);

    vecs.push_back(mk(32'h100, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 0, 32'h80,  0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 0, 32'h80,  0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 0, 1, 0, 32'h340, 1, 32'h300, 0, 32'h204, 1, 32'h340));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 0, 1, 1, 32'h340, 1, 32'h340, 1, 32'h340, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h140, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h0));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 1, 0, 0, 32'h340, 1, 32'h340, 1, 32'h340, 1, 32'h204));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 1, 0, 0, 32'h340, 1, 32'h340, 1, 32'h340, 1, 32'h204));
    vecs.push_back(mk(32'h200, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h0));
    vecs.push_back(mk(32'h208, 0, 1, 32'h208, 0, 1, 1, 32'h400, 0, 32'h0,   0, 32'h20C, 1, 32'h400));
    vecs.push_back(mk(32'h208, 1, 1, 32'h208, 0, 0, 0, 32'h0,   1, 32'h400, 1, 32'h400, 1, 32'h20C));
    vecs.push_back(mk(32'h208, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h20C, 0, 32'h0));
    vecs.push_back(mk(32'h208, 0, 1, 32'h208, 0, 1, 1, 32'h400, 0, 32'h0,   0, 32'h20C, 1, 32'h400));
    vecs.push_back(mk(32'h208, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h20C, 0, 32'h0));
    vecs.push_back(mk(32'h208, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h0));
    vecs.push_back(mk(32'hFFFFFFFC, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(32'h300, 1, 0, 32'h300, 1, 0, 1, 32'h380, 0, 32'h0,   0, 32'h304, 0, 32'h0));
    vecs.push_back(mk(32'h300, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h304, 0, 32'h0));

    foreach (vecs[n]) begin
      drive(0, vecs[n].if_pc, vecs[n].if_v, vecs[n].ex_v, vecs[n].ex_pc, vecs[n].br,
            vecs[n].jmp, vecs[n].tk, vecs[n].tgt, vecs[n].ptk, vecs[n].ptgt);
      #1;
      check($sformatf("vec%0d_pred_taken", n), {31'd0, PRED_TAKEN}, {31'd0, vecs[n].e_pt});
      check($sformatf("vec%0d_pred_target", n), PRED_TARGET, vecs[n].e_ptgt);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_mispredict", n), {31'd0, MISPREDICT}, {31'd0, vecs[n].e_mis});
      if (vecs[n].e_mis) check($sformatf("vec%0d_redirect", n), REDIRECT_PC, vecs[n].e_rdr);
    end

    // Reset coincident with a mispredicting EX update
    drive(1, 32'h208, 1, 1, 32'h500, 1, 0, 1, 32'h600, 0, 32'h0);
    @(posedge CLK); #1;
    idle();
    #1;
    check("rst_ovr_mispredict", {31'd0, MISPREDICT}, 32'd0);
    check("rst_ovr_redirect", REDIRECT_PC, 32'd0);
    IF_PC = 32'h208; IF_VALID = 1; #1;
    check("rst_ovr_inval_208", {31'd0, PRED_TAKEN}, 32'd0);
    check("rst_ovr_target_208", PRED_TARGET, 32'h20C);
    IF_PC = 32'h500; #1;
    check("rst_ovr_no_alloc_500", {31'd0, PRED_TAKEN}, 32'd0);
    @(posedge CLK); #1;
    check("rst_ovr_quiet", {31'd0, MISPREDICT}, 32'd0);

    // Randomized phase against the reference model
    RESET = 1;
    m_edge(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    for (int c = 0; c < 600; c++) begin
      bit [31:0] ipc, epc, etgt, mtg, ptg;
      bit        ekind_br, ekind_j, mt, pt;
      int        kind;
      ipc = 32'h1000 + ($urandom_range(0, 3) << (IB + 2)) + ($urandom_range(0, N_ENT - 1) << 2);
      epc = 32'h1000 + ($urandom_range(0, 3) << (IB + 2)) + ($urandom_range(0, N_ENT - 1) << 2);
      if ($urandom_range(0, 40) == 0) ipc = 32'hFFFFFFFC;
      kind = $urandom_range(0, 3);
      ekind_br = (kind <= 1);
      ekind_j  = (kind == 2);
      etgt = 32'h2000 + ($urandom_range(0, 7) << 4);
      m_pred(epc, 1, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = $urandom_range(0, 1);
        ptg = 32'h2000 + ($urandom_range(0, 7) << 4);
      end
      drive($urandom_range(0, 63) == 0, ipc, $urandom_range(0, 7) != 0,
            $urandom_range(0, 4) != 0, epc, ekind_br, ekind_j, $urandom_range(0, 1),
            etgt, pt, ptg);
      #1;
      m_pred(IF_PC, IF_VALID, mt, mtg);
      check("rand_pred_taken", {31'd0, PRED_TAKEN}, {31'd0, mt});
      check("rand_pred_target", PRED_TARGET, mtg);
      @(posedge CLK);
      m_edge(RESET, EX_VALID, EX_PC, EX_IS_BRANCH, EX_IS_JUMP, EX_TAKEN, EX_TARGET,
             EX_PRED_TAKEN, EX_PRED_TARGET);
      #1;
      check("rand_mispredict", {31'd0, MISPREDICT}, {31'd0, m_mis});
      if (m_mis) check("rand_redirect", REDIRECT_PC, m_rdr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
